// File: rtl/eth_tx_timestamp_capture_fifo_if.sv
// TX timestamp capture FIFO bus bundle:
// Avalon-ST timestamp input and Avalon-MM CSR slave.
interface eth_tx_timestamp_capture_fifo_if;
  logic         asi_timestamp_fp_valid;
  logic [103:0] asi_timestamp_fp;
  logic         asi_timestamp_fp_ready;
  logic [2:0]   avs_csr_address;
  logic         avs_csr_read;
  logic         avs_csr_write;
  logic [31:0]  avs_csr_writedata;
  logic [31:0]  avs_csr_readdata;

  modport master (
    output asi_timestamp_fp_valid,
    output asi_timestamp_fp,
    input  asi_timestamp_fp_ready,
    output avs_csr_address,
    output avs_csr_read,
    output avs_csr_write,
    output avs_csr_writedata,
    input  avs_csr_readdata
  );

  modport slave (
    input  asi_timestamp_fp_valid,
    input  asi_timestamp_fp,
    output asi_timestamp_fp_ready,
    input  avs_csr_address,
    input  avs_csr_read,
    input  avs_csr_write,
    input  avs_csr_writedata,
    output avs_csr_readdata
  );
endinterface

// File: rtl/eth_tx_timestamp_capture_fifo.sv
// TX egress timestamp FIFO with CSR pop-on-read
// access, sticky overflow and level interrupt.
module eth_tx_timestamp_capture_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic clock,
  input  logic reset,
  eth_tx_timestamp_capture_fifo_if.slave bus,
  output logic irq
);

  localparam logic [ADDR_W:0] FULL_CNT =
    (ADDR_W+1)'(DEPTH);

  logic [103:0]      mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              irq_en_q, irq_en_d;
  logic              drop_q, drop_d;
  logic              ovf_q, ovf_d;
  logic [47:0]       sec_q, sec_d;
  logic [31:0]       ns_q, ns_d;
  logic [15:0]       fns_q, fns_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              irq_q, irq_d;

  logic        full, empty, flush;
  logic        ready, push, drop, rd_fp, pop;
  logic        wr_status, wr_ctrl;
  logic [103:0] head;
  logic [31:0] status;
  logic [31:0] wd;
  logic        unused_wd;

  assign wd        = bus.avs_csr_writedata;
  assign unused_wd = ^{wd[31:19], wd[17:3]};
  assign head      = mem_q[rd_ptr_q];

  assign bus.asi_timestamp_fp_ready = ready;
  assign bus.avs_csr_readdata       = rdata_q;
  assign irq                        = irq_q;

  // Handshake qualification and CSR decode
  always_comb begin
    full      = (count_q == FULL_CNT);
    empty     = (count_q == '0);
    wr_status = bus.avs_csr_write &&
                (bus.avs_csr_address == 3'd0);
    wr_ctrl   = bus.avs_csr_write &&
                (bus.avs_csr_address == 3'd1);
    flush     = wr_ctrl & wd[1];
    ready     = drop_q | (!full & !flush);
    push      = bus.asi_timestamp_fp_valid &
                ready & !full & !flush;
    drop      = bus.asi_timestamp_fp_valid &
                drop_q & full & !flush;
    rd_fp     = bus.avs_csr_read &&
                (bus.avs_csr_address == 3'd2);
    pop       = rd_fp & !empty & !flush;
    status             = '0;
    status[ADDR_W:0]   = count_q;
    status[16]         = empty;
    status[17]         = full;
    status[18]         = ovf_q;
  end

  // Next-state for pointers, control, holding regs and readdata
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    irq_en_d = irq_en_q;
    drop_d   = drop_q;
    sec_d    = sec_q;
    ns_d     = ns_q;
    fns_d    = fns_q;
    rdata_d  = rdata_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(push);
      rd_ptr_d = rd_ptr_q + ADDR_W'(pop);
      count_d  = count_q + (ADDR_W+1)'(push)
                 - (ADDR_W+1)'(pop);
    end
    if (wr_ctrl) begin
      irq_en_d = wd[0];
      drop_d   = wd[2];
    end
    ovf_d = drop | (ovf_q & !(wr_status & wd[18]));
    if (rd_fp) begin
      sec_d = pop ? head[95:48] : '0;
      ns_d  = pop ? head[47:16] : '0;
      fns_d = pop ? head[15:0]  : '0;
    end
    if (bus.avs_csr_read) begin
      case (bus.avs_csr_address)
        3'd0:    rdata_d = status;
        3'd1:    rdata_d = {29'b0, drop_q, 1'b0,
                            irq_en_q};
        3'd2:    rdata_d = pop ?
                   {1'b1, 23'b0, head[103:96]} : '0;
        3'd3:    rdata_d = {16'b0, sec_q[47:32]};
        3'd4:    rdata_d = sec_q[31:0];
        3'd5:    rdata_d = ns_q;
        3'd6:    rdata_d = {16'b0, fns_q};
        default: rdata_d = '0;
      endcase
    end
    irq_d = irq_en_q & (!empty | ovf_q);
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      irq_en_q <= 1'b0;
      drop_q   <= 1'b0;
      ovf_q    <= 1'b0;
      sec_q    <= '0;
      ns_q     <= '0;
      fns_q    <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      irq_en_q <= irq_en_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
      sec_q    <= sec_d;
      ns_q     <= ns_d;
      fns_q    <= fns_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  // Entry storage; contents are don't-care until pushed
  always_ff @(posedge clock) begin
    if (push && !reset)
      mem_q[wr_ptr_q] <= bus.asi_timestamp_fp;
  end

endmodule
